// File: rtl/ao_stim_checker.sv
// Stimulus sequencer and checker for AND-OR gate variants: drives a fixed 12-step
// a/b/c sequence, synchronizes the gate output w and measures its settle latency.
module ao_stim_checker #(
    parameter int unsigned HOLD_CYCLES = 30,
    parameter int unsigned TIMEOUT     = 25,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             w,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic [3:0]       step_idx,
    output logic [CNT_W-1:0] lat,
    output logic             lat_valid,
    output logic [CNT_W-1:0] max_lat,
    output logic             err,
    output logic [3:0]       err_step,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DONE} state_t;

    localparam logic [CNT_W-1:0] TMO_K     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_K    = CNT_W'(HOLD_CYCLES);
    localparam logic [3:0]       LAST_STEP = 4'd11;

    function automatic logic [2:0] step_vec(input logic [3:0] idx);
        logic [2:0] v;
        case (idx)
            4'd0:    v = 3'b000;
            4'd1:    v = 3'b001;
            4'd2:    v = 3'b000;
            4'd3:    v = 3'b010;
            4'd4:    v = 3'b011;
            4'd5:    v = 3'b010;
            4'd6:    v = 3'b110;
            4'd7:    v = 3'b100;
            4'd8:    v = 3'b101;
            4'd9:    v = 3'b100;
            4'd10:   v = 3'b110;
            4'd11:   v = 3'b010;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    state_t           state, state_nxt;
    logic             w_meta, w_s;
    logic             expected;
    logic [CNT_W-1:0] cnt, cnt_nxt, k;
    logic [2:0]       abc_nxt;
    logic [3:0]       step_nxt, err_step_nxt;
    logic [CNT_W-1:0] lat_nxt, max_nxt;
    logic             lat_valid_nxt, err_nxt, busy_nxt, done_nxt;

    assign expected = (a & b) | c;
    assign k        = cnt + CNT_W'(1);

    // w is asynchronous to clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_meta <= 1'b0;
            w_s    <= 1'b0;
        end else begin
            w_meta <= w;
            w_s    <= w_meta;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        abc_nxt       = {a, b, c};
        step_nxt      = step_idx;
        lat_nxt       = lat;
        lat_valid_nxt = 1'b0;
        max_nxt       = max_lat;
        err_nxt       = err;
        err_step_nxt  = err_step;
        busy_nxt      = busy;
        done_nxt      = done;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    step_nxt     = '0;
                    abc_nxt      = step_vec(4'd0);
                    cnt_nxt      = '0;
                    max_nxt      = '0;
                    err_nxt      = 1'b0;
                    err_step_nxt = '0;
                    busy_nxt     = 1'b1;
                    done_nxt     = 1'b0;
                    state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nxt = k;
                if (w_s == expected) begin
                    lat_nxt       = k;
                    lat_valid_nxt = 1'b1;
                    if (k > max_lat) max_nxt = k;
                    state_nxt     = S_HOLD;
                end else if (k == TMO_K) begin
                    lat_nxt       = k;
                    lat_valid_nxt = 1'b1;
                    if (k > max_lat) max_nxt = k;
                    err_nxt       = 1'b1;
                    if (!err) err_step_nxt = step_idx;
                    state_nxt     = S_HOLD;
                end
            end
            S_HOLD: begin
                cnt_nxt = k;
                if (k == HOLD_K) begin
                    if (step_idx == LAST_STEP) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        step_nxt  = step_idx + 4'd1;
                        abc_nxt   = step_vec(step_idx + 4'd1);
                        cnt_nxt   = '0;
                        state_nxt = S_WAIT;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            a         <= 1'b0;
            b         <= 1'b0;
            c         <= 1'b0;
            step_idx  <= '0;
            lat       <= '0;
            lat_valid <= 1'b0;
            max_lat   <= '0;
            err       <= 1'b0;
            err_step  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            {a, b, c}   <= abc_nxt;
            step_idx    <= step_nxt;
            lat         <= lat_nxt;
            lat_valid   <= lat_valid_nxt;
            max_lat     <= max_nxt;
            err         <= err_nxt;
            err_step    <= err_step_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_ao_stim_checker.sv
// Bench for ao_stim_checker: gate models with programmable delay, table-driven and
// randomized runs against a latency model derived from the step rules.
module tb_ao_stim_checker;

    localparam int H   = 30;
    localparam int TMO = 25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0, start2 = 1'b0;
    logic       w, w2;
    logic       a, b, c, a2, b2, c2;
    logic [3:0] step_idx, step_idx2, err_step, err_step2;
    logic [7:0] lat, lat2, max_lat, max_lat2;
    logic       lat_valid, lat_valid2, err, err2, busy, busy2, done, done2;

    always #5 clk = ~clk;

    ao_stim_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .w(w),
        .a(a), .b(b), .c(c), .step_idx(step_idx), .lat(lat), .lat_valid(lat_valid),
        .max_lat(max_lat), .err(err), .err_step(err_step), .busy(busy), .done(done)
    );

    ao_stim_checker #(.HOLD_CYCLES(10), .TIMEOUT(6), .CNT_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .w(w2),
        .a(a2), .b(b2), .c(c2), .step_idx(step_idx2), .lat(lat2), .lat_valid(lat_valid2),
        .max_lat(max_lat2), .err(err2), .err_step(err_step2), .busy(busy2), .done(done2)
    );

    // Gate models: whole-cycle delay line behind an ideal AND-OR
    logic [31:0] hist1 = '0, hist2 = '0;
    bit          g_stuck = 1'b0;
    int          g_dly = 0;
    always @(posedge clk) hist1 <= {hist1[30:0], (a & b) | c};
    always @(posedge clk) hist2 <= {hist2[30:0], (a2 & b2) | c2};
    assign w  = g_stuck ? 1'b0 : (g_dly == 0 ? ((a & b) | c) : hist1[g_dly-1]);
    assign w2 = hist2[3];

    typedef struct packed {
        logic            stuck;
        logic [4:0]      dly;
        logic [11:0][7:0] lat;
        logic [7:0]      mx;
        logic            er;
        logic [3:0]      es;
    } vec_t;

    vec_t       tbl [5];
    logic [2:0] seq [12];
    int         exp_lat [12];
    int         exp_max, exp_es;
    bit         exp_err;
    int         total = 0, bad = 0;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [11:0][7:0] lats12(input int v0, v1, v2, v3, v4, v5,
                                                 v6, v7, v8, v9, v10, v11);
        logic [11:0][7:0] r;
        r[0] = 8'(v0);  r[1] = 8'(v1);  r[2]  = 8'(v2);  r[3]  = 8'(v3);
        r[4] = 8'(v4);  r[5] = 8'(v5);  r[6]  = 8'(v6);  r[7]  = 8'(v7);
        r[8] = 8'(v8);  r[9] = 8'(v9);  r[10] = 8'(v10); r[11] = 8'(v11);
        return r;
    endfunction

    // Latency per step: 1 if expected w equals the previous gate output, else 3 + delay, capped
    task automatic compute_expect(input bit stuck, input int d, input int tmo);
        int prev, e, need;
        prev = 0; exp_max = 0; exp_err = 0; exp_es = 0;
        for (int n = 0; n < 12; n++) begin
            e = (seq[n][2] & seq[n][1]) | seq[n][0];
            if (stuck) need = (e == 0) ? 1 : 1000;
            else       need = (e == prev) ? 1 : 3 + d;
            prev = e;
            exp_lat[n] = (need > tmo) ? tmo : need;
            if (need > tmo && !exp_err) begin
                exp_err = 1;
                exp_es  = n;
            end
            if (exp_lat[n] > exp_max) exp_max = exp_lat[n];
        end
    endtask

    task automatic run_main(input bit stuck, input int d, input logic [11:0][7:0] xl,
                            input int xmx, input bit xer, input int xes, input bit hold);
        int cyc, np, done_cyc;
        g_stuck = stuck;
        g_dly   = d;
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk("apply0_step", step_idx, 0);
        chk("apply0_abc", {a, b, c}, seq[0]);
        chk("apply0_busy_done", {busy, done}, 2'b10);
        np = 0;
        done_cyc = -1;
        while (done_cyc < 0 && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (lat_valid) begin
                if (np < 12) begin
                    chk("lat", lat, xl[np]);
                    chk("lat_step", step_idx, np);
                end
                np++;
            end
            if (cyc % H == 0 && cyc / H < 12) begin
                chk("apply_step", step_idx, cyc / H);
                chk("apply_abc", {a, b, c}, seq[cyc / H]);
            end
            if (done) done_cyc = cyc;
        end
        chk("done_cycle", done_cyc, 12 * H);
        chk("pulses", np, 12);
        chk("max_lat", max_lat, xmx);
        chk("err", err, xer);
        chk("err_step", err_step, xes);
        chk("busy_end", busy, 0);
        chk("abc_end", {a, b, c}, seq[11]);
        if (hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("restart_step", step_idx, 0);
            chk("restart_busy_done", {busy, done}, 2'b10);
            chk("restart_err", err, 0);
            chk("restart_max", max_lat, 0);
            start = 1'b0;
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, {a, b, c, step_idx, lat, lat_valid, max_lat, err, err_step, busy, done}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0][7:0] xl;
        int n, cyc, np, done_cyc;

        seq = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b011, 3'b010,
                3'b110, 3'b100, 3'b101, 3'b100, 3'b110, 3'b010};
        tbl[0] = '{stuck: 1'b0, dly: 5'd0, lat: lats12(1,3,3,1,3,3,3,3,3,3,3,3),
                   mx: 8'd3, er: 1'b0, es: 4'd0};
        tbl[1] = '{stuck: 1'b0, dly: 5'd5, lat: lats12(1,8,8,1,8,8,8,8,8,8,8,8),
                   mx: 8'd8, er: 1'b0, es: 4'd0};
        tbl[2] = '{stuck: 1'b1, dly: 5'd0, lat: lats12(1,25,1,1,25,1,25,1,25,1,25,1),
                   mx: 8'd25, er: 1'b1, es: 4'd1};
        tbl[3] = '{stuck: 1'b0, dly: 5'd22, lat: lats12(1,25,25,1,25,25,25,25,25,25,25,25),
                   mx: 8'd25, er: 1'b0, es: 4'd0};
        tbl[4] = '{stuck: 1'b0, dly: 5'd23, lat: lats12(1,25,25,1,25,25,25,25,25,25,25,25),
                   mx: 8'd25, er: 1'b1, es: 4'd1};

        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("reset_async");
        repeat (3) @(negedge clk);
        chk_reset_vals("reset_held");
        rst_n = 1'b1;

        // Short-hold instance: delay 4 exceeds the 6-cycle timeout on every transition
        compute_expect(1'b0, 4, 6);
        repeat (20) @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        cyc = 0; np = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (lat_valid2) begin
                if (np < 12) chk("d2_lat", lat2, exp_lat[np]);
                if (np == 1) chk("d2_step1_lat", lat2, 6);
                np++;
            end
            if (done2) done_cyc = cyc;
        end
        chk("d2_done_cycle", done_cyc, 120);
        chk("d2_pulses", np, 12);
        chk("d2_err", err2, 1);
        chk("d2_err_step", err_step2, 1);
        chk("d2_max_lat", max_lat2, 6);

        for (int i = 0; i < 5; i++)
            run_main(tbl[i].stuck, int'(tbl[i].dly), tbl[i].lat, int'(tbl[i].mx),
                     tbl[i].er, int'(tbl[i].es), 1'b0);

        for (int r = 0; r < 6; r++) begin
            bit st;
            int d;
            st = ($urandom_range(0, 4) == 0);
            d  = int'($urandom_range(0, 27));
            compute_expect(st, d, TMO);
            for (int k = 0; k < 12; k++) xl[k] = 8'(exp_lat[k]);
            run_main(st, d, xl, exp_max, exp_err, exp_es, 1'b0);
        end

        // Reset mid-run during step 5 of a delayed-gate run
        g_stuck = 1'b0;
        g_dly   = 5;
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (step_idx != 4'd5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("reach_step5", step_idx, 5);
        repeat (15) @(negedge clk);
        chk("pre_reset_max", max_lat, 8);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset_mid_run");
        @(negedge clk);
        chk_reset_vals("reset_mid_held");
        rst_n = 1'b1;
        run_main(1'b0, 0, tbl[0].lat, 3, 1'b0, 0, 1'b0);

        // start held high across a failing run, then restart after done
        run_main(1'b1, 0, tbl[2].lat, 25, 1'b1, 1, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ao_stim_checker.md
# ao_stim_checker

Self-checking stimulus sequencer that sits directly upstream of the AND-OR gate variants and also consumes their output. It drives the fixed 12-step a/b/c input sequence into one gate-under-test. It synchronizes the gate's output w and checks it against the expected function w = (a & b) | c. For every step it measures, in clock cycles, how long w takes to settle, which replaces hand-reading waveform delays.

## Interface
- HOLD_CYCLES, 30, clock edges each step is held, counted from apply to next apply; must be > TIMEOUT and ≤ 2^CNT_W − 1
- TIMEOUT, 25, maximum edges allowed for w to match before a step is failed; must be ≥ 3
- CNT_W, 8, width of cycle counter, lat and max_lat
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level-sampled request to run the sequence; ignored while busy
- w  in  1  output of gate-under-test; asynchronous to clk
- a, b, c  out  1 each  registered stimulus to gate-under-test
- step_idx  out  4  index of the step currently applied, 0..11
- lat  out  CNT_W  latency of the last completed step
- lat_valid  out  1  one-cycle pulse when lat updates
- max_lat  out  CNT_W  running maximum of lat over the current run
- err  out  1  sticky: at least one step timed out in this run
- err_step  out  4  step_idx of the first timed-out step
- busy  out  1  sequence in progress
- done  out  1  run finished; held until the next start

## Operation
- Sequence {a,b,c}, steps 0..11: 000, 001, 000, 010, 011, 010, 110, 100, 101, 100, 110, 010.
- Expected w per step: 0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0 (computed as (a&b)|c, not stored).
- w passes through a 2-flop synchronizer, w_s; its reset value is 0.
- FSM states: IDLE, WAIT, HOLD, DONE.
- IDLE or DONE with start=1 at edge S:
  - step_idx ← 0, a/b/c ← step-0 vector, cnt ← 0;
  - max_lat, err and err_step are cleared;
  - busy ← 1, done ← 0, go to WAIT.
- WAIT, at every edge:
  - cnt increments, giving k = edges since apply.
  - If w_s == expected: lat ← k, lat_valid pulses, max_lat ← max(max_lat, k), go to HOLD.
  - Else if k == TIMEOUT: lat ← TIMEOUT, lat_valid pulses, max_lat is updated the same way, err ← 1. If err was 0, err_step ← step_idx. Go to HOLD.
- HOLD: w_s is ignored, so later glitches on w are not checked.
  - At the edge where k == HOLD_CYCLES, the next step is applied: step_idx+1, new vector, cnt ← 0, go to WAIT.
  - If step_idx == 11, go to DONE instead: busy ← 0, done ← 1, a/b/c hold the step-11 vector.
- Only the first match in WAIT ends the measurement.
- start while busy has no effect.

## Timing
- Reset values: a=b=c=0, step_idx=0, lat=0, lat_valid=0, max_lat=0, err=0, err_step=0, busy=0, done=0, FSM=IDLE, cnt=0.
- rst_n low forces all reset values immediately, including mid-step; the run is abandoned.
- Step 0 is applied at the start edge S. Step n is applied at edge S + n·HOLD_CYCLES. done rises after edge S + 12·HOLD_CYCLES.
- Synchronizer overhead: a zero-delay gate whose output changes gives lat = 3. A step whose expected w equals the previous w gives lat = 1.
- A gate delay of d whole cycles adds d: lat = 3 + d.
- lat_valid is high for exactly one cycle per step, 12 pulses per run.

## Test plan
- Ideal combinational gate, default parameters, start pulsed once:
  - lat sequence 1,3,3,1,3,3,3,3,3,3,3,3;
  - max_lat=3, err=0;
  - done rises 360 cycles after the start edge.
- Gate output delayed 5 cycles:
  - lat = 8 on every transitioning step, 1 on steps 0 and 3;
  - max_lat=8, err=0.
- w stuck at 0:
  - step 1 times out with lat=25, err=1, err_step=1;
  - the run continues; err_step stays 1 even though steps 4, 6, 8 and 10 also fail; done after 360 cycles.
- rst_n pulsed low during step 5:
  - all outputs return to reset values without waiting for a clock edge;
  - a following start restarts from step 0 with a clean max_lat.
- start held high for the entire run:
  - the run is not restarted while busy;
  - after done, the next edge restarts at step 0 with err and max_lat cleared.
- HOLD_CYCLES=10, TIMEOUT=6, gate delay 4 cycles: step 1 (lat 7) times out, err_step=1, lat=6.
